pipe_if_stage: RTL and testbench

PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

---
 rtl/pipe_if_stage_pkg.sv | 25 ++
 rtl/pipe_npc_sel.sv | 46 ++++
 rtl/pipe_if_stage.sv | 121 ++++++++++++
 tb/tb_pipe_if_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: pc-source encodings,
// fixed addresses, and the fetch FSM state type.
package pipe_if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_REG = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  localparam logic [XLEN-1:0] INTR_VEC = 32'h0000_0008;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HELD  = 1'b1
  } if_state_e;

  // Sequential successor address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] p);
    return XLEN'(p + XLEN'(4));
  endfunction

endpackage

// File: rtl/pipe_npc_sel.sv
// Next-PC selection: pcsource mux followed by the eret and interrupt
// overrides. Purely combinational.
module pipe_npc_sel
  import pipe_if_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] rpc,
  input  logic [XLEN-1:0] jpc,
  input  logic [XLEN-1:0] epc,
  input  logic            eret,
  input  logic            intr,
  input  logic            ie,
  input  logic            id_isbr,
  output logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] pc_next,
  output logic            take_intr
);

  always_comb begin
    npc       = pc_plus4(pc);
    pc_next   = npc;
    take_intr = 1'b0;

    case (pcsource)
      PCS_SEQ: npc = pc_plus4(pc);
      PCS_BR:  npc = bpc;
      PCS_REG: npc = rpc;
      PCS_JMP: npc = jpc;
      default: npc = pc_plus4(pc);
    endcase

    // A delay slot or an eret in ID defers the interrupt.
    take_intr = intr & ie & ~id_isbr & ~eret;

    if (eret) begin
      pc_next = epc;
    end else if (take_intr) begin
      pc_next = INTR_VEC;
    end else begin
      pc_next = npc;
    end
  end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with a one-word hold buffer for ID stalls,
// delayed-branch next-PC, and a single-level interrupt / eret mechanism.
module pipe_if_stage
  import pipe_if_stage_pkg::*;
(
  input  logic            clock,
  input  logic            resetn,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] rpc,
  input  logic [XLEN-1:0] jpc,
  input  logic            id_isbr,
  input  logic            eret,
  input  logic            nostall,
  input  logic            intr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] dins,
  output logic [XLEN-1:0] dpc4,
  output logic            dvalid,
  output logic            if_busy,
  output logic            inta,
  output logic [XLEN-1:0] epc
);

  if_state_e       state;
  logic [XLEN-1:0] hold_word;
  logic            ie;

  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] pc_next;
  logic            take_intr;
  logic            advance;
  logic [XLEN-1:0] fetch_word;

  pipe_npc_sel u_npc_sel (
    .pc        (pc),
    .pcsource  (pcsource),
    .bpc       (bpc),
    .rpc       (rpc),
    .jpc       (jpc),
    .epc       (epc),
    .eret      (eret),
    .intr      (intr),
    .ie        (ie),
    .id_isbr   (id_isbr),
    .npc       (npc),
    .pc_next   (pc_next),
    .take_intr (take_intr)
  );

  // Advance condition and the word that moves into IF/ID.
  always_comb begin
    advance    = 1'b0;
    fetch_word = hold_word;
    case (state)
      S_FETCH: begin
        advance    = imem_ready & nostall;
        fetch_word = imem_rdata;
      end
      S_HELD: begin
        advance    = nostall;
        fetch_word = hold_word;
      end
      default: begin
        advance    = 1'b0;
        fetch_word = hold_word;
      end
    endcase
  end

  assign imem_addr = pc;
  assign imem_req  = resetn & (state == S_FETCH);
  assign if_busy   = resetn & (state == S_FETCH) & ~imem_ready;
  assign inta      = resetn & advance & take_intr;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_FETCH;
      pc        <= '0;
      epc       <= '0;
      dins      <= NOP;
      dpc4      <= '0;
      dvalid    <= 1'b0;
      ie        <= 1'b1;
      hold_word <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready && !nostall) begin
            hold_word <= imem_rdata;
            state     <= S_HELD;
          end
        end
        S_HELD: begin
          if (nostall) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase

      if (advance) begin
        dins   <= fetch_word;
        dpc4   <= pc_plus4(pc);
        dvalid <= 1'b1;
        pc     <= pc_next;
        if (eret) begin
          ie <= 1'b1;
        end else if (take_intr) begin
          ie  <= 1'b0;
          epc <= npc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed, table-driven bench for pipe_if_stage with hand-computed
// expected values, plus a short hand-written pc wrap sequence.
module tb_pipe_if_stage;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        id_isbr, eret, nostall, intr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc, dins, dpc4, epc;
  logic        dvalid, if_busy, inta;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  pipe_if_stage dut (
    .clock      (clock),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .id_isbr    (id_isbr),
    .eret       (eret),
    .nostall    (nostall),
    .intr       (intr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc         (pc),
    .dins       (dins),
    .dpc4       (dpc4),
    .dvalid     (dvalid),
    .if_busy    (if_busy),
    .inta       (inta),
    .epc        (epc)
  );

  typedef struct {
    logic        rstn;
    logic [1:0]  ps;
    logic        isbr;
    logic        er;
    logic        ns;
    logic        irq;
    logic        rdy;
    logic [31:0] rdata;
    logic        x_req;
    logic        x_busy;
    logic        x_inta;
    logic [31:0] x_pc;
    logic [31:0] x_dins;
    logic [31:0] x_dpc4;
    logic        x_dv;
    logic [31:0] x_epc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rstn, input logic [1:0] ps, input logic isbr, input logic er,
    input logic ns, input logic irq, input logic rdy, input logic [31:0] rdata,
    input logic x_req, input logic x_busy, input logic x_inta,
    input logic [31:0] x_pc, input logic [31:0] x_dins, input logic [31:0] x_dpc4,
    input logic x_dv, input logic [31:0] x_epc);
    vec_t v;
    v.rstn = rstn; v.ps = ps; v.isbr = isbr; v.er = er; v.ns = ns; v.irq = irq;
    v.rdy = rdy; v.rdata = rdata; v.x_req = x_req; v.x_busy = x_busy;
    v.x_inta = x_inta; v.x_pc = x_pc; v.x_dins = x_dins; v.x_dpc4 = x_dpc4;
    v.x_dv = x_dv; v.x_epc = x_epc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    resetn     = v.rstn;
    pcsource   = v.ps;
    id_isbr    = v.isbr;
    eret       = v.er;
    nostall    = v.ns;
    intr       = v.irq;
    imem_ready = v.rdy;
    imem_rdata = v.rdata;
  endtask

  initial begin
    logic [31:0] exp_addr;
    resetn = 1'b0; pcsource = 2'b00; id_isbr = 1'b0; eret = 1'b0;
    nostall = 1'b0; intr = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    bpc = 32'h0000_0200; rpc = 32'h0000_0300; jpc = 32'h0000_0400;

    //            rstn ps    isbr er  ns  irq rdy rdata          req busy inta pc             dins           dpc4           dv  epc
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0, 1, 32'hDEAD_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000));
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 0, 1, 32'hA000_0001, 1, 0, 0, 32'h0000_0004, 32'hA000_0001, 32'h0000_0004, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 0, 1, 32'hA000_0002, 1, 0, 0, 32'h0000_0008, 32'hA000_0002, 32'h0000_0008, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 0, 1, 32'hA000_0003, 1, 0, 0, 32'h0000_000C, 32'hA000_0003, 32'h0000_000C, 1, 32'h0000_0000));
    // memory not ready for two cycles
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 0, 0, 32'hBAD0_0000, 1, 1, 0, 32'h0000_000C, 32'hA000_0003, 32'h0000_000C, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 0, 0, 32'hBAD0_0001, 1, 1, 0, 32'h0000_000C, 32'hA000_0003, 32'h0000_000C, 1, 32'h0000_0000));
    // ID stalled: word goes to the hold buffer, later rdata is ignored
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 1, 32'hB000_0001, 1, 0, 0, 32'h0000_000C, 32'hA000_0003, 32'h0000_000C, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 1, 32'hBAD0_0002, 0, 0, 0, 32'h0000_000C, 32'hA000_0003, 32'h0000_000C, 1, 32'h0000_0000));
    // release from held with a branch: buffered word is the delay slot
    vecs.push_back(mk(1, 2'b01, 0, 0, 1, 0, 1, 32'hBAD0_0003, 0, 0, 0, 32'h0000_0200, 32'hB000_0001, 32'h0000_0010, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 2'b10, 0, 0, 1, 0, 1, 32'hC000_0001, 1, 0, 0, 32'h0000_0300, 32'hC000_0001, 32'h0000_0204, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 2'b11, 0, 0, 1, 0, 1, 32'hC000_0002, 1, 0, 0, 32'h0000_0400, 32'hC000_0002, 32'h0000_0304, 1, 32'h0000_0000));
    // interrupt deferred by delay slot, then taken
    vecs.push_back(mk(1, 2'b00, 1, 0, 1, 1, 1, 32'hC000_0003, 1, 0, 0, 32'h0000_0404, 32'hC000_0003, 32'h0000_0404, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 1, 1, 32'hC000_0004, 1, 0, 1, 32'h0000_0008, 32'hC000_0004, 32'h0000_0408, 1, 32'h0000_0408));
    // ie now 0: interrupt ignored
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 1, 1, 32'hC000_0005, 1, 0, 0, 32'h0000_000C, 32'hC000_0005, 32'h0000_000C, 1, 32'h0000_0408));
    // eret beats intr and pcsource
    vecs.push_back(mk(1, 2'b01, 0, 1, 1, 1, 1, 32'hC000_0006, 1, 0, 0, 32'h0000_0408, 32'hC000_0006, 32'h0000_0010, 1, 32'h0000_0408));
    // no advance: no interrupt even with ie=1
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 1, 0, 32'hBAD0_0004, 1, 1, 0, 32'h0000_0408, 32'hC000_0006, 32'h0000_0010, 1, 32'h0000_0408));
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 1, 1, 32'hC000_0007, 1, 0, 1, 32'h0000_0008, 32'hC000_0007, 32'h0000_040C, 1, 32'h0000_040C));
    // go to held, then reset discards the held word
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 1, 32'hD000_0001, 1, 0, 0, 32'h0000_0008, 32'hC000_0007, 32'h0000_040C, 1, 32'h0000_040C));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1, 1, 32'hBAD0_0005, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000));
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 0, 1, 32'hD000_0002, 1, 0, 0, 32'h0000_0004, 32'hD000_0002, 32'h0000_0004, 1, 32'h0000_0000));

    exp_addr = '0;
    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      #1;
      chk("imem_req", i, 32'(imem_req), 32'(vecs[i].x_req));
      chk("if_busy",  i, 32'(if_busy),  32'(vecs[i].x_busy));
      chk("inta",     i, 32'(inta),     32'(vecs[i].x_inta));
      if (i > 0) chk("imem_addr", i, imem_addr, exp_addr);
      @(posedge clock);
      #1;
      chk("pc",     i, pc,          vecs[i].x_pc);
      chk("dins",   i, dins,        vecs[i].x_dins);
      chk("dpc4",   i, dpc4,        vecs[i].x_dpc4);
      chk("dvalid", i, 32'(dvalid), 32'(vecs[i].x_dv));
      chk("epc",    i, epc,         vecs[i].x_epc);
      exp_addr = vecs[i].x_pc;
    end

    // pc wrap: jump to 0xFFFF_FFFC, then sequential fetch wraps to 0
    @(negedge clock);
    jpc = 32'hFFFF_FFFC; pcsource = 2'b11; intr = 1'b0; nostall = 1'b1;
    imem_ready = 1'b1; imem_rdata = 32'hE000_0001;
    @(posedge clock); #1;
    chk("wrap_jump_pc", 100, pc, 32'hFFFF_FFFC);
    @(negedge clock);
    pcsource = 2'b00; imem_rdata = 32'hE000_0002;
    #1;
    chk("wrap_addr", 101, imem_addr, 32'hFFFF_FFFC);
    @(posedge clock); #1;
    chk("wrap_pc",   102, pc,   32'h0000_0000);
    chk("wrap_dpc4", 103, dpc4, 32'h0000_0000);
    chk("wrap_dins", 104, dins, 32'hE000_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
